dataflow_deadlock_monitor: RTL and testbench
============================================

# dataflow_deadlock_monitor

- Simulation-side monitor for HLS dataflow regions with N_PROC processes.
- Watches per-process "blocked" and "waiting-on" vectors and filters out transient stalls with per-process persistence counters.
- Confirms a circular wait by reachability probing over a snapshot of the wait graph.
- Reports the origin process and the set of participating processes; the report is sticky.
- Sits beside the design-under-test in the testbench, one instance per dataflow region, and generalises the fixed three-process detector.

## Interface
Parameters:
- N_PROC, default 3: number of dataflow processes (2..32).
- DEP_MASK, default all-ones of width N_PROC*N_PROC: bit i*N_PROC+j set means process i may legally wait on process j.
- STALL_THRESH, default 16: consecutive blocked cycles before a process is considered persistent (≥1).
- CNT_W, default $clog2(STALL_THRESH+1): stall counter width.

Ports:
- clock  in  1  sampling clock, rising edge.
- reset  in  1  reset, asynchronous, active-low.
- blk_vec  in  N_PROC  process i is currently stalled on a FIFO or start handshake.
- blk_dst  in  N_PROC*N_PROC  bits [i*N_PROC +: N_PROC] give the processes that i is waiting on this cycle.
- clear  in  1  synchronous clear of report, counters and FSM.
- dl_detect  out  1  sticky deadlock flag.
- dl_origin  out  $clog2(N_PROC)  process from which the cycle was found.
- dl_members  out  N_PROC  processes reachable from the origin in the confirmed wait graph; always includes the origin.
- dl_abort  out  1  one-cycle pulse when a probe is abandoned.
- probe_busy  out  1  FSM is in PROBE.

## Operation
- wait[i] = blk_dst row i & DEP_MASK row i.
- blocked_eff[i] = blk_vec[i] & |wait[i].
- Counter cnt[i]:
  - On each edge, cnt[i] increments if blocked_eff[i], saturating at STALL_THRESH; otherwise it goes to 0.
  - persist[i] = (cnt[i] == STALL_THRESH).
- rr_ptr: round-robin start index for origin selection, reset 0.
- FSM states IDLE, PROBE, REPORT (reset IDLE).
- IDLE, if |persist:
  - origin = first persistent index at or after rr_ptr, wrapping.
  - snap = persist.
  - G[i] = snap[i] ? wait[i] & snap : 0.
  - R = G[origin]; iter = 1.
  - Next state PROBE.
- PROBE, evaluated in this priority order:
  1. Any snap[j] with persist[j] now 0: abort.
  2. R[origin] set: confirm.
  3. iter == N_PROC: abort.
  4. Otherwise R = R | OR over j∈R of G[j]; iter++.
- Abort: dl_abort = 1 for one cycle, rr_ptr = (origin+1) mod N_PROC, next state IDLE.
- Confirm: dl_detect = 1, dl_origin = origin, dl_members = R, next state REPORT.
- REPORT: outputs hold; counters keep running; no new probe is started.
- clear, any state, highest priority: next state IDLE; all counters, rr_ptr, dl_* and the snapshot go to 0. A confirm in the same cycle as clear is discarded.
- A self-loop (wait[o][o] with o persistent) confirms on the first PROBE cycle.

## Timing
- Reset values: dl_detect 0, dl_origin 0, dl_members 0, dl_abort 0, probe_busy 0, all counters 0.
- Reset is asynchronous assert, synchronous release. Reset mid-probe discards everything.
- Persistence: blocked_eff held from the cycle before edge 1 gives persist high after edge STALL_THRESH.
- Capture occurs on the next edge, E0; probe_busy is high from E0.
- For a cycle of length k through the origin, dl_detect rises at edge E0+k (k ≤ N_PROC).
- Non-cyclic snapshot: dl_abort pulses after edge E0+N_PROC.
- Early abort: if a member unblocks during PROBE, dl_abort pulses the edge after its counter clears.
- Re-probe no earlier than one IDLE cycle after an abort.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- N_PROC=3, STALL_THRESH=4, ring 0→1→2→0 held from cycle 0:
  - dl_detect rises at edge 8, dl_origin=0, dl_members=3'b111, dl_abort never pulses.
- Chain 0→1 with process 1 not blocked:
  - no probe ever starts (snapshot empty path), or, if 1 is persistent but points nowhere, dl_abort after E0+3.
  - dl_detect stays 0.
- Ring 0→1→2→0 formed, then process 2 unblocks one cycle after E0:
  - dl_abort pulses, rr_ptr=1.
  - Re-block → new probe with origin 1, confirmed with dl_origin=1.
- Self-loop on process 2 only, STALL_THRESH=1:
  - dl_detect at E0+1, dl_origin=2, dl_members=3'b100.
- DEP_MASK clearing edge 2→0, ring stimulus applied:
  - edge filtered, blocked_eff[2]=0, no detection.
- Confirmed deadlock then clear for one cycle with the ring still present:
  - outputs go to 0 the next edge.
  - Counters restart and re-detection occurs STALL_THRESH+1+3 edges later.

Source files
------------

// File: rtl/dataflow_deadlock_monitor_if.sv
// Purpose : bundle of the observed dataflow-region status and the monitor report.
// Latency : n/a (signal bundle only).
// Backpres: none; the monitor is a passive observer.
// Ports   : master = testbench/region side (drives blk_vec, blk_dst, clear),
//           slave  = monitor side (drives dl_detect, dl_origin, dl_members,
//                    dl_abort, probe_busy).
interface dataflow_deadlock_monitor_if #(
  parameter int N_PROC = 3
);
  localparam int IDX_W = $clog2(N_PROC);

  logic [N_PROC-1:0]        blk_vec;
  logic [N_PROC*N_PROC-1:0] blk_dst;
  logic                     clear;
  logic                     dl_detect;
  logic [IDX_W-1:0]         dl_origin;
  logic [N_PROC-1:0]        dl_members;
  logic                     dl_abort;
  logic                     probe_busy;

  modport master (
    output blk_vec, blk_dst, clear,
    input  dl_detect, dl_origin, dl_members, dl_abort, probe_busy
  );

  modport slave (
    input  blk_vec, blk_dst, clear,
    output dl_detect, dl_origin, dl_members, dl_abort, probe_busy
  );
endinterface

// File: rtl/dataflow_deadlock_monitor.sv
// Purpose : detects circular waits among N_PROC dataflow processes and reports a sticky deadlock.
// Latency : persist after STALL_THRESH blocked edges, capture one edge later (E0), confirm at E0+k.
// Backpres: none; passive monitor, never stalls the observed region.
// Ports   : clock, reset (async active-low, release expected synchronous to clock),
//           mon.blk_vec / mon.blk_dst / mon.clear in,
//           mon.dl_detect / dl_origin / dl_members / dl_abort / probe_busy out (all registered).
module dataflow_deadlock_monitor #(
  parameter int                       N_PROC       = 3,
  parameter logic [N_PROC*N_PROC-1:0] DEP_MASK     = '1,
  parameter int                       STALL_THRESH = 16,
  parameter int                       CNT_W        = $clog2(STALL_THRESH+1)
) (
  input  logic                        clock,
  input  logic                        reset,
  dataflow_deadlock_monitor_if.slave  mon
);

  localparam int IDX_W  = $clog2(N_PROC);
  localparam int ITER_W = $clog2(N_PROC+1);

  typedef enum logic [1:0] {IDLE, PROBE, REPORT} state_t;

  // Filtered wait graph and persistence
  logic [N_PROC-1:0] wait_m [N_PROC];
  logic [N_PROC-1:0] blocked_eff;
  logic [N_PROC-1:0] persist;
  logic [CNT_W-1:0]  cnt [N_PROC];

  always_comb begin
    for (int i = 0; i < N_PROC; i++) begin
      wait_m[i]      = mon.blk_dst[i*N_PROC +: N_PROC] & DEP_MASK[i*N_PROC +: N_PROC];
      blocked_eff[i] = mon.blk_vec[i] & (|wait_m[i]);
      persist[i]     = (cnt[i] == CNT_W'(STALL_THRESH));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_PROC; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_PROC; i++) begin
        if (mon.clear || !blocked_eff[i]) cnt[i] <= '0;
        else if (!persist[i])             cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end

  // Probe FSM state
  state_t            state_q, state_n;
  logic [IDX_W-1:0]  rr_q, rr_n;
  logic [IDX_W-1:0]  origin_q, origin_n;
  logic [N_PROC-1:0] snap_q, snap_n;
  logic [N_PROC-1:0] g_q [N_PROC];
  logic [N_PROC-1:0] g_n [N_PROC];
  logic [N_PROC-1:0] r_q, r_n;
  logic [ITER_W-1:0] iter_q, iter_n;
  logic              det_q, det_n;
  logic [IDX_W-1:0]  dorg_q, dorg_n;
  logic [N_PROC-1:0] dmem_q, dmem_n;
  logic              abort_q, abort_n;
  logic              busy_q, busy_n;

  // Origin search helpers
  logic              found;
  logic [IDX_W-1:0]  sel;
  logic [IDX_W-1:0]  idx;
  int                t;

  always_comb begin
    state_n  = state_q;
    rr_n     = rr_q;
    origin_n = origin_q;
    snap_n   = snap_q;
    g_n      = g_q;
    r_n      = r_q;
    iter_n   = iter_q;
    det_n    = det_q;
    dorg_n   = dorg_q;
    dmem_n   = dmem_q;
    abort_n  = 1'b0;
    found    = 1'b0;
    sel      = '0;
    idx      = '0;
    t        = 0;

    case (state_q)
      IDLE: begin
        if (|persist) begin
          // first persistent process at or after rr_q, wrapping
          for (int k = 0; k < N_PROC; k++) begin
            t = int'(rr_q) + k;
            if (t >= N_PROC) t = t - N_PROC;
            idx = IDX_W'(t);
            if (!found && persist[idx]) begin
              found = 1'b1;
              sel   = idx;
            end
          end
          origin_n = sel;
          snap_n   = persist;
          for (int i = 0; i < N_PROC; i++)
            g_n[i] = persist[i] ? (wait_m[i] & persist) : '0;
          // origin is persistent, so its graph row is wait & snapshot
          r_n      = wait_m[sel] & persist;
          iter_n   = ITER_W'(1);
          state_n  = PROBE;
        end
      end

      PROBE: begin
        if (|(snap_q & ~persist)) begin
          // a snapshot member recovered: the graph is stale
          abort_n = 1'b1;
          rr_n    = (origin_q == IDX_W'(N_PROC-1)) ? '0 : origin_q + 1'b1;
          state_n = IDLE;
        end else if (r_q[origin_q]) begin
          det_n   = 1'b1;
          dorg_n  = origin_q;
          dmem_n  = r_q;
          state_n = REPORT;
        end else if (iter_q == ITER_W'(N_PROC)) begin
          abort_n = 1'b1;
          rr_n    = (origin_q == IDX_W'(N_PROC-1)) ? '0 : origin_q + 1'b1;
          state_n = IDLE;
        end else begin
          for (int j = 0; j < N_PROC; j++)
            if (r_q[j]) r_n = r_n | g_q[j];
          iter_n = iter_q + 1'b1;
        end
      end

      REPORT: begin
        // report is sticky until clear or reset
      end

      default: state_n = IDLE;
    endcase

    if (mon.clear) begin
      state_n  = IDLE;
      rr_n     = '0;
      origin_n = '0;
      snap_n   = '0;
      for (int i = 0; i < N_PROC; i++) g_n[i] = '0;
      r_n      = '0;
      iter_n   = '0;
      det_n    = 1'b0;
      dorg_n   = '0;
      dmem_n   = '0;
      abort_n  = 1'b0;
    end

    busy_n = (state_n == PROBE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      origin_q <= '0;
      snap_q   <= '0;
      for (int i = 0; i < N_PROC; i++) g_q[i] <= '0;
      r_q      <= '0;
      iter_q   <= '0;
      det_q    <= 1'b0;
      dorg_q   <= '0;
      dmem_q   <= '0;
      abort_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      rr_q     <= rr_n;
      origin_q <= origin_n;
      snap_q   <= snap_n;
      for (int i = 0; i < N_PROC; i++) g_q[i] <= g_n[i];
      r_q      <= r_n;
      iter_q   <= iter_n;
      det_q    <= det_n;
      dorg_q   <= dorg_n;
      dmem_q   <= dmem_n;
      abort_q  <= abort_n;
      busy_q   <= busy_n;
    end
  end

  assign mon.dl_detect  = det_q;
  assign mon.dl_origin  = dorg_q;
  assign mon.dl_members = dmem_q;
  assign mon.dl_abort   = abort_q;
  assign mon.probe_busy = busy_q;

endmodule

// File: tb/tb_dataflow_deadlock_monitor.sv
// Purpose : self-checking bench for dataflow_deadlock_monitor; two instances
//           (A: THRESH=4 full mask, B: THRESH=1 with edge 2->0 masked).
// Ports   : none; drives both instances through their interfaces.
module tb_dataflow_deadlock_monitor;

  localparam logic [8:0] MASK_B = 9'b110_111_111;            // clears bit 2*3+0
  localparam logic [8:0] RING   = {3'b001, 3'b100, 3'b010};  // 0->1, 1->2, 2->0
  localparam logic [8:0] CHAIN  = {3'b000, 3'b000, 3'b010};  // 0->1 only
  localparam logic [8:0] SELF2  = {3'b100, 3'b000, 3'b000};  // 2->2

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  dataflow_deadlock_monitor_if #(.N_PROC(3)) if_a ();
  dataflow_deadlock_monitor_if #(.N_PROC(3)) if_b ();

  dataflow_deadlock_monitor #(.N_PROC(3), .STALL_THRESH(4)) u_a (
    .clock (clock),
    .reset (reset),
    .mon   (if_a)
  );

  dataflow_deadlock_monitor #(.N_PROC(3), .DEP_MASK(MASK_B), .STALL_THRESH(1)) u_b (
    .clock (clock),
    .reset (reset),
    .mon   (if_b)
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // scoreboard of expected report events
  typedef struct {
    int inst;
    bit abort;
    int edge_n;
    int origin;
    int members;
  } ev_t;

  ev_t sb[$];

  task automatic push_ev(input int inst, input bit ab, input int edge_n,
                         input int org, input int mem);
    ev_t e;
    e.inst = inst; e.abort = ab; e.edge_n = edge_n; e.origin = org; e.members = mem;
    sb.push_back(e);
  endtask

  task automatic observe(input int inst, input logic ab, input logic det,
                         input logic det_prev, input logic [1:0] org,
                         input logic [2:0] mem);
    ev_t e;
    if (ab === 1'b1 || (det === 1'b1 && det_prev === 1'b0)) begin
      if (sb.size() == 0) begin
        check($sformatf("unexpected_abort_%0d", inst), {31'd0, ab}, 32'd0);
        check($sformatf("unexpected_detect_%0d", inst), {31'd0, det}, {31'd0, det_prev});
      end else begin
        e = sb.pop_front();
        check("ev_inst", inst, e.inst);
        check("ev_kind_abort", {31'd0, ab}, {31'd0, e.abort});
        check("ev_edge", cyc, e.edge_n);
        if (!e.abort) begin
          check("ev_origin", {30'd0, org}, e.origin);
          check("ev_members", {29'd0, mem}, e.members);
        end
      end
    end
  endtask

  logic det_a_q = 1'b0;
  logic det_b_q = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      while (sb.size() > 0 && sb[0].edge_n < cyc) begin
        check("missed_event_edge", cyc, sb[0].edge_n);
        void'(sb.pop_front());
      end
      observe(0, if_a.dl_abort, if_a.dl_detect, det_a_q, if_a.dl_origin, if_a.dl_members);
      observe(1, if_b.dl_abort, if_b.dl_detect, det_b_q, if_b.dl_origin, if_b.dl_members);
      det_a_q = if_a.dl_detect;
      det_b_q = if_b.dl_detect;
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_a();
    if_a.blk_vec = '0;
    if_a.blk_dst = '0;
    if_a.clear   = 1'b1;
    wait_neg(1);
    if_a.clear   = 1'b0;
  endtask

  int c;
  int d;

  initial begin
    if_a.blk_vec = '0; if_a.blk_dst = '0; if_a.clear = 1'b0;
    if_b.blk_vec = '0; if_b.blk_dst = '0; if_b.clear = 1'b0;
    wait_neg(3);
    check("a_rst_detect",  {31'd0, if_a.dl_detect}, 0);
    check("a_rst_origin",  {30'd0, if_a.dl_origin}, 0);
    check("a_rst_members", {29'd0, if_a.dl_members}, 0);
    check("a_rst_abort",   {31'd0, if_a.dl_abort}, 0);
    check("a_rst_busy",    {31'd0, if_a.probe_busy}, 0);
    check("b_rst_detect",  {31'd0, if_b.dl_detect}, 0);
    check("b_rst_busy",    {31'd0, if_b.probe_busy}, 0);
    reset = 1'b1;
    wait_neg(1);

    // A1: ring held from cycle 0 -> detect at edge 8, origin 0, members 111
    c = cyc;
    if_a.blk_vec = 3'b111; if_a.blk_dst = RING;
    push_ev(0, 1'b0, c + 8, 0, 7);
    wait_neg(4);
    check("a_busy_before_e0", {31'd0, if_a.probe_busy}, 0);
    wait_neg(1);
    check("a_busy_at_e0", {31'd0, if_a.probe_busy}, 1);
    wait_neg(7);
    check("a_report_hold", {31'd0, if_a.dl_detect}, 1);
    check("a_report_members", {29'd0, if_a.dl_members}, 7);
    check("a_report_busy", {31'd0, if_a.probe_busy}, 0);

    // clear for one cycle with the ring still present
    d = cyc;
    if_a.clear = 1'b1;
    wait_neg(1);
    if_a.clear = 1'b0;
    check("a_clear_detect",  {31'd0, if_a.dl_detect}, 0);
    check("a_clear_members", {29'd0, if_a.dl_members}, 0);
    check("a_clear_origin",  {30'd0, if_a.dl_origin}, 0);
    push_ev(0, 1'b0, d + 1 + 4 + 1 + 3, 0, 7);
    wait_neg(10);

    // A2: ring forms, everything unblocks one cycle after E0, then re-blocks
    clear_a();
    c = cyc;
    if_a.blk_vec = 3'b111; if_a.blk_dst = RING;
    push_ev(0, 1'b1, c + 7, 0, 0);
    wait_neg(5);
    check("a2_busy_at_e0", {31'd0, if_a.probe_busy}, 1);
    if_a.blk_vec = 3'b000;
    wait_neg(2);
    check("a2_busy_after_abort", {31'd0, if_a.probe_busy}, 0);
    wait_neg(1);
    if_a.blk_vec = 3'b111;
    push_ev(0, 1'b0, c + 16, 1, 7);
    wait_neg(10);

    // A3: chain 0->1, process 1 blocked but pointing nowhere
    clear_a();
    c = cyc;
    if_a.blk_vec = 3'b011; if_a.blk_dst = CHAIN;
    push_ev(0, 1'b1, c + 8, 0, 0);
    push_ev(0, 1'b1, c + 12, 0, 0);
    wait_neg(11);
    if_a.blk_vec = 3'b000;
    wait_neg(10);
    check("a3_no_detect", {31'd0, if_a.dl_detect}, 0);
    check("a3_idle", {31'd0, if_a.probe_busy}, 0);

    // B1: ring with edge 2->0 masked, STALL_THRESH=1 -> aborts only
    c = cyc;
    if_b.blk_vec = 3'b111; if_b.blk_dst = RING;
    push_ev(1, 1'b1, c + 5, 0, 0);
    push_ev(1, 1'b1, c + 9, 0, 0);
    wait_neg(8);
    if_b.blk_vec = 3'b000;
    wait_neg(6);
    check("b1_no_detect", {31'd0, if_b.dl_detect}, 0);

    // B2: self-loop on process 2 -> detect at E0+1
    c = cyc;
    if_b.blk_vec = 3'b100; if_b.blk_dst = SELF2;
    push_ev(1, 1'b0, c + 3, 2, 4);
    wait_neg(5);
    check("b2_report_busy", {31'd0, if_b.probe_busy}, 0);
    check("b2_origin", {30'd0, if_b.dl_origin}, 2);

    wait_neg(2);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
